pipe_shifter: RTL and testbench

PIPE_SHIFTER -- requirements
Module: pipe_shifter

---
 rtl/shifter_pkg.sv | 20 ++
 rtl/shift_stage.sv | 51 +++++
 rtl/pipe_shifter.sv | 133 +++++++++++++
 tb/tb_pipe_shifter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
// -----------------------------------------------------------------------------
// shifter_pkg
// Shared definitions for the pipelined barrel shifter.
//   - Operation encoding carried on the in_op port and through the pipe.
//   - group_width(): number of shift-amount bits resolved per pipe stage.
// -----------------------------------------------------------------------------
package shifter_pkg;

    localparam logic [1:0] OP_SLL = 2'b00;  // logical left, zero fill
    localparam logic [1:0] OP_SRL = 2'b01;  // logical right, zero fill
    localparam logic [1:0] OP_SRA = 2'b10;  // arithmetic right, sign fill
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

    // Bits of shamt handled by each stage: ceil(shamt_w / stages).
    // Trailing stages may get fewer bits, or none at all.
    function automatic int group_width(input int shamt_w, input int stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Purely combinational partial shifter. Applies the shamt bits in the range
// [LO, LO+NBITS) to data_in for the given op; every other shamt bit is left
// for another stage. NBITS = 0 gives a pass-through stage.
//   data_in  : operand as produced by the previous stage
//   shamt    : full shift amount (only this stage's group is applied)
//   op       : SLL / SRL / SRA / ROR
//   data_out : partially shifted operand
// -----------------------------------------------------------------------------
module shift_stage
    import shifter_pkg::*;
#(
    parameter int WIDTH   = 64,
    parameter int SHAMT_W = 6,
    parameter int LO      = 0,
    parameter int NBITS   = 1
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   data_out
);

    logic [WIDTH-1:0]        acc;
    logic signed [WIDTH-1:0] acc_s;

    // Each shamt bit j contributes a shift of 2**j; applying them one after
    // another composes to the full amount for all four operations. For SRA
    // the MSB is preserved at every step, so later stages still fill with
    // the original sign bit.
    always_comb begin
        acc   = data_in;
        acc_s = '0;
        for (int j = 0; j < SHAMT_W; j++) begin
            if (j >= LO && j < LO + NBITS && shamt[j]) begin
                case (op)
                    OP_SLL:  acc = acc << (1 << j);
                    OP_SRL:  acc = acc >> (1 << j);
                    OP_SRA: begin
                        acc_s = acc;
                        acc   = acc_s >>> (1 << j);
                    end
                    default: acc = (acc >> (1 << j)) | (acc << (WIDTH - (1 << j)));
                endcase
            end
        end
        data_out = acc;
    end

endmodule

// File: rtl/pipe_shifter.sv
// -----------------------------------------------------------------------------
// pipe_shifter
// Pipelined barrel shifter with valid/ready flow control. The shift amount is
// resolved PIPE_STAGES bit-groups at a time (lowest group first), one group
// per register stage. All stages advance together whenever the output
// register is empty or being drained; otherwise the whole pipe freezes.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake (in_ready is the pipe advance)
//   in_a, in_b           : operand and shift amount (low log2(WIDTH) bits)
//   in_op, in_tag        : operation and sideband tag
//   out_valid / out_ready: output handshake
//   out_y, out_tag       : result and its tag
//   out_zero             : result is all zeros
// -----------------------------------------------------------------------------
module pipe_shifter
    import shifter_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int GW      = group_width(SHAMT_W, PIPE_STAGES);
    localparam int LAST    = PIPE_STAGES - 1;

    // Per-stage registered state
    logic               valid_reg [PIPE_STAGES];
    logic [WIDTH-1:0]   data_reg  [PIPE_STAGES];
    logic [SHAMT_W-1:0] shamt_reg [PIPE_STAGES];
    logic [1:0]         op_reg    [PIPE_STAGES];
    logic [TAG_W-1:0]   tag_reg   [PIPE_STAGES];
    logic               zero_reg;

    // Per-stage inputs (from the ports for stage 0, else from the previous stage)
    logic               v_in     [PIPE_STAGES];
    logic [WIDTH-1:0]   d_in     [PIPE_STAGES];
    logic [SHAMT_W-1:0] shamt_in [PIPE_STAGES];
    logic [1:0]         op_in    [PIPE_STAGES];
    logic [TAG_W-1:0]   tag_in   [PIPE_STAGES];
    logic [WIDTH-1:0]   d_out    [PIPE_STAGES];

    logic adv;

    // Upper bits of the shift amount are deliberately ignored.
    logic unused_b;
    assign unused_b = ^in_b[WIDTH-1:SHAMT_W];

    assign adv      = !valid_reg[LAST] || out_ready;
    assign in_ready = adv;

    generate
        for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
            localparam int LO    = gi * GW;
            localparam int NBITS = (LO >= SHAMT_W)     ? 0 :
                                   (SHAMT_W - LO < GW) ? (SHAMT_W - LO) : GW;

            if (gi == 0) begin : g_head
                assign v_in[gi]     = in_valid;
                assign d_in[gi]     = in_a;
                assign shamt_in[gi] = in_b[SHAMT_W-1:0];
                assign op_in[gi]    = in_op;
                assign tag_in[gi]   = in_tag;
            end else begin : g_body
                assign v_in[gi]     = valid_reg[gi-1];
                assign d_in[gi]     = data_reg[gi-1];
                assign shamt_in[gi] = shamt_reg[gi-1];
                assign op_in[gi]    = op_reg[gi-1];
                assign tag_in[gi]   = tag_reg[gi-1];
            end

            shift_stage #(
                .WIDTH   (WIDTH),
                .SHAMT_W (SHAMT_W),
                .LO      (LO),
                .NBITS   (NBITS)
            ) u_shift_stage (
                .data_in  (d_in[gi]),
                .shamt    (shamt_in[gi]),
                .op       (op_in[gi]),
                .data_out (d_out[gi])
            );

            // Bubbles (v_in = 0) are loaded like any other entry so spacing
            // between operations is preserved through the pipe.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg[gi] <= 1'b0;
                    data_reg[gi]  <= '0;
                    shamt_reg[gi] <= '0;
                    op_reg[gi]    <= '0;
                    tag_reg[gi]   <= '0;
                end else if (adv) begin
                    valid_reg[gi] <= v_in[gi];
                    data_reg[gi]  <= d_out[gi];
                    shamt_reg[gi] <= shamt_in[gi];
                    op_reg[gi]    <= op_in[gi];
                    tag_reg[gi]   <= tag_in[gi];
                end
            end
        end
    endgenerate

    // Zero flag is registered alongside the final stage so out_zero is a
    // flop output and reads 0 in reset even though out_y is also 0 then.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_reg <= 1'b0;
        end else if (adv) begin
            zero_reg <= v_in[LAST] && (d_out[LAST] == '0);
        end
    end

    assign out_valid = valid_reg[LAST];
    assign out_y     = data_reg[LAST];
    assign out_tag   = tag_reg[LAST];
    assign out_zero  = zero_reg;

endmodule

// File: tb/tb_pipe_shifter.sv
// -----------------------------------------------------------------------------
// tb_pipe_shifter
// Self-checking bench for pipe_shifter (WIDTH=64, PIPE_STAGES=2, TAG_W=4).
// Accepted inputs are pushed into a scoreboard with a result computed from
// plain shift/rotate arithmetic; every output handshake is checked against it.
// -----------------------------------------------------------------------------
module tb_pipe_shifter;
    import shifter_pkg::*;

    localparam int WIDTH       = 64;
    localparam int PIPE_STAGES = 2;
    localparam int TAG_W       = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    always #5 clk = ~clk;

    pipe_shifter #(
        .WIDTH       (WIDTH),
        .PIPE_STAGES (PIPE_STAGES),
        .TAG_W       (TAG_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_tag   (out_tag),
        .out_zero  (out_zero)
    );

    typedef struct {
        logic [WIDTH-1:0] y;
        logic [TAG_W-1:0] tag;
        int               cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   cyc       = 0;
    bit   check_lat = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Reference: shift amount is b modulo the width, then textbook shifts.
    function automatic logic [WIDTH-1:0] ref_shift(input logic [1:0] op,
                                                   input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        int s;
        logic signed [WIDTH-1:0] sa;
        s  = int'(b % WIDTH);
        sa = a;
        case (op)
            OP_SLL:  return a << s;
            OP_SRL:  return a >> s;
            OP_SRA:  return sa >>> s;
            default: return (s == 0) ? a : ((a >> s) | (a << (WIDTH - s)));
        endcase
    endfunction

    // One clock cycle: drive at the falling edge, then observe both
    // handshakes just before the next rising edge.
    task automatic step(input bit v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [1:0] op, input logic [TAG_W-1:0] tag, input bit ordy,
                        input bit use_exp = 1'b0, input logic [WIDTH-1:0] exp_y = '0);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_op     = op;
        in_tag    = tag;
        out_ready = ordy;
        #1;
        cyc++;
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                $display("out tag=%0h y=%h zero=%0b", out_tag, out_y, out_zero);
                check("out_y", out_y, e.y);
                check("out_tag", 64'(out_tag), 64'(e.tag));
                check("out_zero", 64'(out_zero), 64'(e.y == '0));
                if (check_lat) check("latency", 64'(cyc - e.cyc), 64'(PIPE_STAGES));
            end
        end
        if (in_valid && in_ready) begin
            sb.push_back('{use_exp ? exp_y : ref_shift(op, a, b), tag, cyc});
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, OP_SLL, '0, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] a0;
        logic [WIDTH-1:0] y_hold;
        logic [TAG_W-1:0] t_hold;

        a0        = 64'h800000000000000A;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = OP_SLL;
        in_tag    = '0;
        out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_y", out_y, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_out_zero", 64'(out_zero), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with known results, no backpressure
        check_lat = 1'b1;
        step(1'b1, a0, 64'd1,  OP_SRL, 4'd1, 1'b1, 1'b1, 64'h4000000000000005);
        step(1'b1, a0, 64'd1,  OP_SRA, 4'd2, 1'b1, 1'b1, 64'hC000000000000005);
        step(1'b1, a0, 64'd4,  OP_SLL, 4'd3, 1'b1, 1'b1, 64'h00000000000000A0);
        step(1'b1, a0, 64'd4,  OP_ROR, 4'd4, 1'b1, 1'b1, 64'hA800000000000000);
        step(1'b1, a0, 64'd65, OP_SRL, 4'd5, 1'b1, 1'b1, 64'h4000000000000005);
        step(1'b1, 64'd1, 64'd1, OP_SRL, 4'd6, 1'b1, 1'b1, 64'd0);
        idle(4);
        check("directed_drained", 64'(sb.size()), 64'd0);

        // Back-to-back: 8 inputs, tags 0..7; latency check forces consecutive outputs
        for (int t = 0; t < 8; t++) begin
            step(1'b1, {$urandom, $urandom}, 64'($urandom_range(0, 127)),
                 2'($urandom_range(0, 3)), 4'(t), 1'b1);
        end
        idle(4);
        check("b2b_drained", 64'(sb.size()), 64'd0);

        // Backpressure: stall for 3 cycles with a result pending
        check_lat = 1'b0;
        step(1'b1, {$urandom, $urandom}, 64'd7,  OP_ROR, 4'd9,  1'b1);
        step(1'b1, {$urandom, $urandom}, 64'd13, OP_SRA, 4'd10, 1'b1);
        y_hold = '0;
        t_hold = '0;
        for (int k = 0; k < 3; k++) begin
            // Offer an input during the stall; it must not be taken.
            step(1'b1, {$urandom, $urandom}, 64'd3, OP_SLL, 4'd15, 1'b0);
            check("bp_out_valid", 64'(out_valid), 64'd1);
            check("bp_in_ready", 64'(in_ready), 64'd0);
            if (k == 0) begin
                check("bp_front_y", out_y, sb[0].y);
                y_hold = out_y;
                t_hold = out_tag;
            end else begin
                check("bp_hold_y", out_y, y_hold);
                check("bp_hold_tag", 64'(out_tag), 64'(t_hold));
            end
        end
        idle(5);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with two operations in flight
        step(1'b1, {$urandom, $urandom}, 64'd2, OP_SRL, 4'd11, 1'b1);
        step(1'b1, {$urandom, $urandom}, 64'd3, OP_SLL, 4'd12, 1'b1);
        step(1'b0, '0, '0, OP_SLL, '0, 1'b0);
        check("pre_rst_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", 64'(out_valid), 64'd0);
        check("async_rst_out_y", out_y, 64'd0);
        check("async_rst_out_tag", 64'(out_tag), 64'd0);
        check("async_rst_in_ready", 64'(in_ready), 64'd1);
        sb.delete();
        step(1'b0, '0, '0, OP_SLL, '0, 1'b1);
        step(1'b0, '0, '0, OP_SLL, '0, 1'b1);
        rst_n = 1'b1;
        check_lat = 1'b1;
        step(1'b1, a0, 64'd4, OP_SLL, 4'd13, 1'b1, 1'b1, 64'h00000000000000A0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);
        check("post_rst_accepted", 64'(sb.size()), 64'd1);
        step(1'b0, '0, '0, OP_SLL, '0, 1'b1);
        check("post_rst_no_stale", 64'(out_valid), 64'd0);
        idle(4);
        check("post_rst_drained", 64'(sb.size()), 64'd0);

        // Randomized traffic with random backpressure
        check_lat = 1'b0;
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, {$urandom, $urandom}, {$urandom, $urandom},
                 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3) != 0);
        end
        idle(10);
        check("random_drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
